ghash_msg_sequencer: RTL

- Upstream stage of the GHASH control signal unit.
- Takes the per-packet block count from the static register file and tracks incoming bus words. Each bus word carries BLOCK_PROC_PAR 128-bit blocks.
- Generates the message count, tail-bubble count, skip-bus and qualified valid signals that the control signal unit consumes.
- Holds off new packets until the control unit reports hash done.

---
 rtl/ghash_msg_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/ghash_msg_sequencer.sv
// rtl/ghash_msg_sequencer.sv - GHASH message sequencer: block counting and word qualification
//
// Purpose:
//   Upstream stage of the GHASH control signal unit. Opens a packet on i_start,
//   latches the packet block count, and tracks accepted bus words. Each word
//   carries BLOCK_PROC_PAR 128-bit blocks. Produces the per-word message count,
//   tail bubble count, skip-bus and last-word flags. New packets are held off
//   until the control unit reports hash done.
//
// Ports:
//   i_clock                 clock
//   i_reset                 synchronous active-high reset
//   i_start                 one-cycle pulse opening a packet
//   i_valid                 bus word present this cycle
//   i_rf_static_n_messages  total blocks in the packet, sampled on accepted start
//   i_hash_done             hash complete pulse from the control signal unit
//   o_valid                 registered accepted-word strobe
//   o_msg_count             blocks consumed before the current word
//   o_msg_bubbles           empty block slots in the final word
//   o_skip_bus              current word carries no data (empty packet)
//   o_last_word             current word is the final word of the packet
//   o_busy                  packet in progress
//   o_error                 one-cycle protocol violation pulse
module ghash_msg_sequencer #(
  parameter int NB_N_MESSAGES       = 10,
  parameter int LOG2_BLOCK_PROC_PAR = 2,
  parameter int BLOCK_PROC_PAR      = 4
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic                           i_start,
  input  logic                           i_valid,
  input  logic [NB_N_MESSAGES-1:0]       i_rf_static_n_messages,
  input  logic                           i_hash_done,
  output logic                           o_valid,
  output logic [NB_N_MESSAGES-1:0]       o_msg_count,
  output logic [LOG2_BLOCK_PROC_PAR-1:0] o_msg_bubbles,
  output logic                           o_skip_bus,
  output logic                           o_last_word,
  output logic                           o_busy,
  output logic                           o_error
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] RUN       = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;

  logic [1:0]                     state, state_next;
  logic [NB_N_MESSAGES-1:0]       counter, counter_next;
  logic [NB_N_MESSAGES-1:0]       n_lat, n_next;
  logic [LOG2_BLOCK_PROC_PAR-1:0] bubbles, bubbles_next;
  logic [NB_N_MESSAGES:0]         sum;
  logic                           accept;
  logic                           last;
  logic                           err;

  // One extra bit so the final-word increment at max n cannot wrap.
  assign sum = {1'b0, counter} + (NB_N_MESSAGES+1)'(BLOCK_PROC_PAR);

  always_comb begin
    state_next   = state;
    counter_next = counter;
    n_next       = n_lat;
    bubbles_next = bubbles;
    accept       = 1'b0;
    last         = 1'b0;
    err          = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          state_next   = RUN;
          n_next       = i_rf_static_n_messages;
          counter_next = '0;
          // (0 - n) mod BLOCK_PROC_PAR only depends on the low bits of n.
          bubbles_next = LOG2_BLOCK_PROC_PAR'(0) - i_rf_static_n_messages[LOG2_BLOCK_PROC_PAR-1:0];
        end
        if (i_valid || i_hash_done) err = 1'b1;
      end
      RUN: begin
        if (i_valid) begin
          accept = 1'b1;
          if (sum >= {1'b0, n_lat}) begin
            last       = 1'b1;
            state_next = WAIT_DONE;
          end else begin
            counter_next = sum[NB_N_MESSAGES-1:0];
          end
        end
        if (i_start || i_hash_done) err = 1'b1;
      end
      WAIT_DONE: begin
        if (i_hash_done) state_next = IDLE;
        if (i_valid || i_start) err = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= IDLE;
      counter       <= '0;
      n_lat         <= '0;
      bubbles       <= '0;
      o_valid       <= 1'b0;
      o_msg_count   <= '0;
      o_msg_bubbles <= '0;
      o_skip_bus    <= 1'b0;
      o_last_word   <= 1'b0;
      o_busy        <= 1'b0;
      o_error       <= 1'b0;
    end else begin
      state       <= state_next;
      counter     <= counter_next;
      n_lat       <= n_next;
      bubbles     <= bubbles_next;
      o_valid     <= accept;
      o_last_word <= last;
      o_skip_bus  <= accept && (n_lat == '0);
      if (accept) begin
        o_msg_count   <= counter;
        o_msg_bubbles <= bubbles;
      end
      // Tracks the state register itself, so use the next-state value.
      o_busy  <= (state_next != IDLE);
      o_error <= err;
    end
  end

endmodule
